// File: rtl/sipo_frame_ctrl_if.sv
// Interface between the serial front end, the frame controller and the parallel word consumer.
interface sipo_frame_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic             s_valid;
   logic             s_in;
   logic             busy;
   logic [WIDTH-1:0] q_out;
   logic             q_valid;
   logic             q_ready;
   logic             overrun;
   logic             ovr_clr;
   logic             parity_err;

   modport master (
      output start, s_valid, s_in, q_ready, ovr_clr,
      input  busy, q_out, q_valid, overrun, parity_err
   );

   modport slave (
      input  start, s_valid, s_in, q_ready, ovr_clr,
      output busy, q_out, q_valid, overrun, parity_err
   );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Frames an LSB-first serial stream into WIDTH-bit words behind a 1-deep valid/ready buffer.
// Optional trailing parity bit check enabled by defining PARITY_CHK_EN.
module sipo_frame_ctrl #(
   parameter int unsigned WIDTH   = 4,
   parameter bit          PAR_ODD = 1'b0
) (
   input logic              clk,
   input logic              rst,
   sipo_frame_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
`ifdef PARITY_CHK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SHIFT, PAR, LOAD} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sr, sr_d;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
   logic [WIDTH-1:0]   q_out_d;
   logic               q_valid_d, overrun_d, busy_d, parity_err_d;
   logic               par_mis_c, buf_free_c, drop_c;

   // Next-state, datapath and registered-output next values
   always_comb begin
      state_nxt    = state;
      sr_d         = sr;
      bit_cnt_d    = bit_cnt;
      q_out_d      = bus.q_out;
      q_valid_d    = bus.q_valid;
      overrun_d    = bus.overrun;
      parity_err_d = 1'b0;
      drop_c       = 1'b0;
      par_mis_c    = ((^sr) ^ bus.s_in) != PAR_ODD;
      buf_free_c   = !bus.q_valid || bus.q_ready;

      if (bus.q_valid && bus.q_ready) q_valid_d = 1'b0;

      case (state)
         IDLE: begin
            // A bit arriving alongside start belongs to no frame yet
            if (bus.start) begin
               state_nxt = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (bus.s_valid) begin
               sr_d      = {bus.s_in, sr[WIDTH-1:1]};
               bit_cnt_d = bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(WIDTH - 1)) state_nxt = PAR_EN ? PAR : LOAD;
            end
         end
         PAR: begin
            if (bus.s_valid) begin
               state_nxt    = LOAD;
               parity_err_d = PAR_EN && par_mis_c;
            end
         end
         LOAD: begin
            state_nxt = IDLE;
            if (buf_free_c) begin
               q_out_d   = sr;
               q_valid_d = 1'b1;
            end else begin
               drop_c    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // A drop in the same cycle as a clear leaves overrun set
      if (drop_c)           overrun_d = 1'b1;
      else if (bus.ovr_clr) overrun_d = 1'b0;

      busy_d = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr             <= '0;
         bit_cnt        <= '0;
         bus.q_out      <= '0;
         bus.q_valid    <= 1'b0;
         bus.overrun    <= 1'b0;
         bus.busy       <= 1'b0;
         bus.parity_err <= 1'b0;
      end else begin
         sr             <= sr_d;
         bit_cnt        <= bit_cnt_d;
         bus.q_out      <= q_out_d;
         bus.q_valid    <= q_valid_d;
         bus.overrun    <= overrun_d;
         bus.busy       <= busy_d;
         bus.parity_err <= parity_err_d;
      end
   end
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_sipo_frame_ctrl;
   localparam int unsigned WIDTH   = 4;
   localparam bit          PAR_ODD = 1'b0;
`ifdef PARITY_CHK_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif

   logic clk = 1'b0;
   logic rst;
   sipo_frame_ctrl_if #(.WIDTH(WIDTH)) bus ();

   sipo_frame_ctrl #(.WIDTH(WIDTH), .PAR_ODD(PAR_ODD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: frame progress as a bit queue, plus the output buffer
   bit               m_in_frame, m_load, m_busy, m_qv, m_ovr, m_perr;
   logic [WIDTH-1:0] m_qo, m_word;
   bit               bits[$];
   bit               cur_qr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input bit st, input bit sv, input bit si, input bit qr,
                             input bit oc, input bit r);
      bit set_ovr;
      int ones;
      set_ovr = 1'b0;
      if (r) begin
         m_in_frame = 0; m_load = 0; m_busy = 0; m_qv = 0; m_ovr = 0; m_perr = 0;
         m_qo = '0;
         bits.delete();
         return;
      end
      if (m_load) begin
         if (!m_qv || qr) begin
            m_qo = m_word;
            m_qv = 1'b1;
         end else begin
            m_ovr   = 1'b1;
            set_ovr = 1'b1;
         end
      end else if (m_qv && qr) begin
         m_qv = 1'b0;
      end
      if (oc && !set_ovr) m_ovr = 1'b0;

      m_perr = 1'b0;
      if (m_load) begin
         m_load = 1'b0;
      end else if (m_in_frame) begin
         if (sv) begin
            bits.push_back(si);
            if (bits.size() == WIDTH + NPAR) begin
               m_word = '0;
               ones   = 0;
               for (int i = 0; i < WIDTH + NPAR; i++) begin
                  if (i < WIDTH) m_word = m_word | (WIDTH'(bits[i]) << i);
                  ones += int'(bits[i]);
               end
               m_perr     = (NPAR == 1) && ((ones % 2) != int'(PAR_ODD));
               m_load     = 1'b1;
               m_in_frame = 1'b0;
            end
         end
      end else if (st) begin
         m_in_frame = 1'b1;
         bits.delete();
      end
      m_busy = m_in_frame || m_load;
   endtask

   task automatic cyc(input bit st, input bit sv, input bit si, input bit qr,
                      input bit oc, input bit r);
      bus.start = st; bus.s_valid = sv; bus.s_in = si;
      bus.q_ready = qr; bus.ovr_clr = oc; rst = r;
      @(posedge clk);
      model_edge(st, sv, si, qr, oc, r);
      @(negedge clk);
      check("busy",       32'(bus.busy),       32'(m_busy));
      check("q_valid",    32'(bus.q_valid),    32'(m_qv));
      check("q_out",      32'(bus.q_out),      32'(m_qo));
      check("overrun",    32'(bus.overrun),    32'(m_ovr));
      check("parity_err", 32'(bus.parity_err), 32'(m_perr));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'($urandom % 2), cur_qr, 1'b0, 1'b0);
   endtask

   // Ends at the negedge following the edge that samples the last frame bit (DUT in LOAD)
   task automatic send_frame(input logic [WIDTH-1:0] w, input int max_gap, input bit bad_par);
      bit b;
      cyc(1'b1, 1'b0, 1'b0, cur_qr, 1'b0, 1'b0);
      for (int i = 0; i < WIDTH + NPAR; i++) begin
         idle(int'($urandom_range(max_gap, 0)));
         if (i < WIDTH) b = w[i];
         else           b = (^w) ^ PAR_ODD ^ bad_par;
         cyc(1'b0, 1'b1, b, cur_qr, 1'b0, 1'b0);
      end
   endtask

   initial begin
      bus.start = 0; bus.s_valid = 0; bus.s_in = 0; bus.q_ready = 0; bus.ovr_clr = 0; rst = 1;
      cur_qr = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // T1: reset mid-frame
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);
      check("t1_busy", 32'(bus.busy), 32'd0);
      check("t1_qv",   32'(bus.q_valid), 32'd0);
      check("t1_qout", 32'(bus.q_out), 32'd0);
      check("t1_ovr",  32'(bus.overrun), 32'd0);

      // T2: basic word, 2-cycle latency
      cur_qr = 1'b0;
      send_frame(4'b1101, 0, 1'b0);
      check("t2_qv_early", 32'(bus.q_valid), 32'd0);
      idle(1);
      check("t2_qv",   32'(bus.q_valid), 32'd1);
      check("t2_qout", 32'(bus.q_out), 32'hD);
      cur_qr = 1'b1; idle(2); cur_qr = 1'b0;

      // T3: stalls between bits
      for (int k = 0; k < 3; k++) begin
         send_frame(4'b1101, 3, 1'b0);
         idle(1);
         check("t3_qout", 32'(bus.q_out), 32'hD);
         cur_qr = 1'b1; idle(1); cur_qr = 1'b0;
      end

      // T4: overrun, then clear
      send_frame(4'hA, 1, 1'b0); idle(2);
      send_frame(4'h5, 1, 1'b0); idle(2);
      check("t4_qout", 32'(bus.q_out), 32'hA);
      check("t4_ovr",  32'(bus.overrun), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("t4_clr",  32'(bus.overrun), 32'd0);
      cur_qr = 1'b1; idle(2); cur_qr = 1'b0;

      // T5: back-to-back refill during LOAD
      send_frame(4'hC, 0, 1'b0); idle(2);
      send_frame(4'h3, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("t5_qout", 32'(bus.q_out), 32'h3);
      check("t5_qv",   32'(bus.q_valid), 32'd1);
      check("t5_ovr",  32'(bus.overrun), 32'd0);
      cur_qr = 1'b1; idle(2); cur_qr = 1'b0;

`ifdef PARITY_CHK_EN
      // T6: parity error pulse, word still loaded
      send_frame(4'b0111, 0, 1'b1);
      check("t6_perr_bad", 32'(bus.parity_err), 32'd1);
      idle(1);
      check("t6_qout_bad", 32'(bus.q_out), 32'h7);
      check("t6_perr_end", 32'(bus.parity_err), 32'd0);
      cur_qr = 1'b1; idle(1); cur_qr = 1'b0;
      send_frame(4'b0111, 0, 1'b0);
      check("t6_perr_ok", 32'(bus.parity_err), 32'd0);
      idle(1);
      check("t6_qout_ok", 32'(bus.q_out), 32'h7);
`endif

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(1'(($urandom % 4) == 0), 1'($urandom % 2), 1'($urandom % 2),
             1'($urandom % 2), 1'(($urandom % 10) == 0), 1'(($urandom % 256) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
